// File: rtl/spi_apb_sequencer.sv
// rtl/spi_apb_sequencer.sv - APB master sequencing a slave-mode SPI core
//
// Purpose: writes the SPI core's control register once after reset. It then
// drains received bytes from the core's RX data register into a small FIFO, and
// forwards user transmit bytes into the core's TX data register. The APB is
// APB2-style (no PREADY), so every transfer is SETUP then ACCESS. Each transfer
// is followed by GAP_CYCLES idle cycles so the core's status flags can settle.
//
// Ports:
//   PCLK, PRESET          clock, synchronous active-high reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA   APB master port to the core
//   rx_data_ready         core has a received byte (level)
//   tx_reg_empty          core can accept a TX byte (level)
//   tx_data/tx_valid/tx_ready   user transmit byte stream (one holding register)
//   rx_data/rx_valid/rx_ready   user receive byte stream (FIFO head)
//   rx_full               receive FIFO full
//   cfg_done              control register written since reset
module spi_apb_sequencer #(
  parameter logic [3:0] CTRL_ADDR  = 4'h0,
  parameter logic [3:0] RXD_ADDR   = 4'h2,
  parameter logic [3:0] TXD_ADDR   = 4'h3,
  parameter logic [7:0] CTRL_VALUE = 8'h05,
  parameter int         RX_DEPTH   = 4,
  parameter int         GAP_CYCLES = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  output logic [3:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       rx_data_ready,
  input  logic       tx_reg_empty,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_full,
  output logic       cfg_done
);

  localparam int         AW       = $clog2(RX_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);
  localparam logic [2:0]  GAP_LAST = 3'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    INIT, CFG_SETUP, CFG_ACCESS, GAP, IDLE,
    RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS
  } state_t;

  state_t        state, state_next;
  logic [2:0]    gap_cnt;
  logic          hold_valid;
  logic [7:0]    hold_data;
  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop;

  assign push       = (state == RD_ACCESS);
  assign pop        = rx_valid && rx_ready;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  assign tx_ready   = cfg_done && !hold_valid;
  assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;

  always_comb begin
    state_next = state;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    PADDR      = 4'h0;
    PWDATA     = 8'h00;
    case (state)
      INIT:       state_next = CFG_SETUP;
      CFG_SETUP: begin
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = CTRL_ADDR; PWDATA = CTRL_VALUE;
        state_next = CFG_ACCESS;
      end
      CFG_ACCESS: begin
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = CTRL_ADDR; PWDATA = CTRL_VALUE;
        state_next = GAP;
      end
      GAP:        if (gap_cnt == GAP_LAST) state_next = IDLE;
      IDLE: begin
        // RX drains first so the core's receive register does not overrun.
        if (rx_data_ready && !rx_full)     state_next = RD_SETUP;
        else if (hold_valid && tx_reg_empty) state_next = WR_SETUP;
      end
      RD_SETUP: begin
        PSEL = 1'b1; PADDR = RXD_ADDR;
        state_next = RD_ACCESS;
      end
      RD_ACCESS: begin
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = RXD_ADDR;
        state_next = GAP;
      end
      WR_SETUP: begin
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = TXD_ADDR; PWDATA = hold_data;
        state_next = WR_ACCESS;
      end
      WR_ACCESS: begin
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = TXD_ADDR; PWDATA = hold_data;
        state_next = GAP;
      end
      default:    state_next = INIT;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= INIT;
      gap_cnt    <= 3'd0;
      cfg_done   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_valid   <= 1'b0;
      rx_full    <= 1'b0;
    end else begin
      state   <= state_next;
      gap_cnt <= (state == GAP) ? gap_cnt + 3'd1 : 3'd0;
      if (state == CFG_ACCESS) cfg_done <= 1'b1;
      // The holding register cannot be loaded while WR_ACCESS is running,
      // because tx_ready is low whenever it is full.
      if (state == WR_ACCESS) begin
        hold_valid <= 1'b0;
      end else if (tx_valid && tx_ready) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_data;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      // Flags come from the next count so they line up with the pointers.
      rx_valid <= (count_next != '0);
      rx_full  <= (count_next == FULL_CNT);
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= PRDATA;
  end

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// tb/tb_spi_apb_sequencer.sv - directed self-checking bench for spi_apb_sequencer
module tb_spi_apb_sequencer;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [3:0] PADDR;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA, PRDATA;
  logic       rx_data_ready, tx_reg_empty, tx_valid, tx_ready;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, rx_ready, rx_full, cfg_done;

  int n_vec = 0;
  int n_err = 0;

  // Core read-data model: each completed read advances the byte by one.
  logic [7:0] prdata_base = 8'h00;
  logic [7:0] rd_done = 8'h00;
  assign PRDATA = prdata_base + rd_done;

  int cyc = 0;
  int n_acc = 0;
  int n_wr = 0;
  logic [3:0] last_addr = 4'h0;
  logic [7:0] last_wdata = 8'h00;
  logic [3:0] acc_addr[$];
  int         acc_cyc[$];

  spi_apb_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA),
    .rx_data_ready(rx_data_ready), .tx_reg_empty(tx_reg_empty),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_full(rx_full), .cfg_done(cfg_done)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (PSEL && PENABLE && !PWRITE) rd_done <= rd_done + 8'd1;
  end

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      n_acc = n_acc + 1;
      acc_addr.push_back(PADDR);
      acc_cyc.push_back(cyc);
      if (PWRITE) begin
        n_wr       = n_wr + 1;
        last_addr  = PADDR;
        last_wdata = PWDATA;
      end
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic check_apb(input string tag, input logic sel, input logic en, input logic wr,
                           input logic [3:0] addr, input logic [7:0] wdata);
    expect_eq({tag, "_psel"}, 32'(PSEL), 32'(sel));
    expect_eq({tag, "_penable"}, 32'(PENABLE), 32'(en));
    expect_eq({tag, "_pwrite"}, 32'(PWRITE), 32'(wr));
    expect_eq({tag, "_paddr"}, 32'(PADDR), 32'(addr));
    expect_eq({tag, "_pwdata"}, 32'(PWDATA), 32'(wdata));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_apb(tag, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    expect_eq({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
    expect_eq({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    expect_eq({tag, "_rx_full"}, 32'(rx_full), 32'd0);
    expect_eq({tag, "_cfg_done"}, 32'(cfg_done), 32'd0);
    expect_eq({tag, "_rx_data"}, 32'(rx_data), 32'd0);
  endtask

  task automatic check_config(input string tag);
    step();
    check_apb({tag, "_setup"}, 1'b1, 1'b0, 1'b1, 4'h0, 8'h05);
    expect_eq({tag, "_cfg_done_c1"}, 32'(cfg_done), 32'd0);
    step();
    check_apb({tag, "_access"}, 1'b1, 1'b1, 1'b1, 4'h0, 8'h05);
    step();
    expect_eq({tag, "_cfg_done_c3"}, 32'(cfg_done), 32'd1);
    expect_eq({tag, "_psel_gap"}, 32'(PSEL), 32'd0);
  endtask

  initial begin
    int         acc0, w0, i0;
    logic [7:0] r0;

    PRESET = 1'b1; rx_data_ready = 1'b0; tx_reg_empty = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    steps(3);
    check_reset_outputs("reset");
    PRESET = 1'b0;
    check_config("cfg");
    expect_eq("cfg_tx_ready", 32'(tx_ready), 32'd1);
    steps(2);
    acc0 = n_acc;
    steps(10);
    expect_eq("idle_no_xfer", 32'(n_acc - acc0), 32'd0);

    // Single RX byte
    prdata_base = 8'hA5 - rd_done;
    rx_data_ready = 1'b1;
    step();
    check_apb("rd_setup", 1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    step();
    check_apb("rd_access", 1'b1, 1'b1, 1'b0, 4'h2, 8'h00);
    expect_eq("rd_valid_early", 32'(rx_valid), 32'd0);
    rx_data_ready = 1'b0;
    step();
    expect_eq("rd_valid", 32'(rx_valid), 32'd1);
    expect_eq("rd_data", 32'(rx_data), 32'hA5);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    expect_eq("pop_valid", 32'(rx_valid), 32'd0);
    expect_eq("pop_data", 32'(rx_data), 32'h00);
    steps(3);

    // RX FIFO fills and stalls
    r0 = rd_done;
    prdata_base = 8'h01 - rd_done;
    rx_data_ready = 1'b1;
    for (int i = 0; i < 100 && !rx_full; i++) step();
    expect_eq("full_set", 32'(rx_full), 32'd1);
    expect_eq("full_reads", 32'(rd_done - r0), 32'd4);
    steps(20);
    expect_eq("stall_reads", 32'(rd_done - r0), 32'd4);
    expect_eq("stall_full", 32'(rx_full), 32'd1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    for (int i = 0; i < 100 && !rx_full; i++) step();
    expect_eq("refill_full", 32'(rx_full), 32'd1);
    expect_eq("refill_reads", 32'(rd_done - r0), 32'd5);
    rx_data_ready = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      expect_eq("order_valid", 32'(rx_valid), 32'd1);
      expect_eq("order_data", 32'(rx_data), 32'(i));
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
    end
    expect_eq("drained", 32'(rx_valid), 32'd0);
    steps(4);

    // TX byte with core ready
    tx_reg_empty = 1'b1;
    expect_eq("tx_ready_idle", 32'(tx_ready), 32'd1);
    tx_data = 8'h3C; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    expect_eq("tx_ready_n1", 32'(tx_ready), 32'd0);
    expect_eq("tx_psel_n1", 32'(PSEL), 32'd0);
    step();
    check_apb("wr_setup", 1'b1, 1'b0, 1'b1, 4'h3, 8'h3C);
    expect_eq("tx_ready_setup", 32'(tx_ready), 32'd0);
    step();
    check_apb("wr_access", 1'b1, 1'b1, 1'b1, 4'h3, 8'h3C);
    expect_eq("tx_ready_access", 32'(tx_ready), 32'd0);
    step();
    expect_eq("tx_ready_n4", 32'(tx_ready), 32'd1);
    expect_eq("tx_psel_n4", 32'(PSEL), 32'd0);
    steps(4);

    // TX held while core is busy
    tx_reg_empty = 1'b0;
    w0 = n_wr;
    tx_data = 8'h77; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    steps(15);
    expect_eq("hold_no_write", 32'(n_wr - w0), 32'd0);
    expect_eq("hold_tx_ready", 32'(tx_ready), 32'd0);
    tx_reg_empty = 1'b1;
    for (int i = 0; i < 50 && n_wr == w0; i++) step();
    expect_eq("hold_writes", 32'(n_wr - w0), 32'd1);
    expect_eq("hold_wdata", 32'(last_wdata), 32'h77);
    expect_eq("hold_addr", 32'(last_addr), 32'h3);
    steps(5);

    // RX and TX requested in the same IDLE cycle
    tx_reg_empty = 1'b0;
    tx_data = 8'h5A; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    i0 = acc_addr.size();
    r0 = rd_done;
    w0 = n_wr;
    prdata_base = 8'hC3 - rd_done;
    rx_data_ready = 1'b1;
    tx_reg_empty = 1'b1;
    step();
    check_apb("cont_first", 1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    for (int i = 0; i < 20 && rd_done == r0; i++) step();
    rx_data_ready = 1'b0;
    for (int i = 0; i < 50 && n_wr == w0; i++) step();
    expect_eq("cont_count", 32'(acc_addr.size() - i0), 32'd2);
    if (acc_addr.size() >= i0 + 2) begin
      expect_eq("cont_rd_addr", 32'(acc_addr[i0]), 32'h2);
      expect_eq("cont_wr_addr", 32'(acc_addr[i0+1]), 32'h3);
      expect_eq("cont_spacing", 32'(acc_cyc[i0+1] - acc_cyc[i0]), 32'd5);
    end
    expect_eq("cont_wdata", 32'(last_wdata), 32'h5A);
    expect_eq("cont_rx_data", 32'(rx_data), 32'hC3);
    steps(5);

    // Reset during RD_ACCESS with one byte still queued
    rx_data_ready = 1'b1;
    for (int i = 0; i < 20 && !(PSEL && PENABLE); i++) step();
    expect_eq("mid_in_access", 32'(PSEL && PENABLE && !PWRITE), 32'd1);
    PRESET = 1'b1;
    step();
    check_reset_outputs("mid_reset");
    PRESET = 1'b0;
    rx_data_ready = 1'b0;
    check_config("recfg");
    expect_eq("recfg_rx_valid", 32'(rx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
